// File: rtl/vga_scan.sv
// -----------------------------------------------------------------------------
// vga_scan
//
// Raster scan generator for a VGA-style display. A horizontal pixel counter
// and a vertical line counter walk the full frame (active + front porch +
// sync + back porch). The generator addresses a frame store with the current
// pixel coordinate and then registers the pixel colour together with the
// sync, blank and frame-start signals.
//
// One pipeline stage: every output registered on an enabled edge describes
// the pixel the counters pointed at *before* that edge. Because of that,
// h_addr/v_addr (combinational) always run one pixel ahead of the
// registered colour and sync outputs.
//
// en is a pixel-advance strobe, not a handshake. On an edge with en=0 the
// counters and every registered output hold their values. frame_start is
// the one exception: it drops to 0 on every non-advancing edge, so it is
// high for only one clock per frame.
//
// Ports
//   clk          pixel clock; every state change happens on its rising edge
//   rst          synchronous, active-high reset
//   en           pixel-advance enable
//   vga_data     {R,G,B} that the frame store returns combinationally for
//                h_addr/v_addr
//   h_addr       pixel column to the frame store (0 outside the active area)
//   v_addr       pixel row to the frame store (0 outside the active area)
//   hsync        active-low horizontal sync, registered
//   vsync        active-low vertical sync, registered
//   valid        active-video flag (drives VGA_BLANK_N), registered
//   vga_r/g/b    pixel colour, registered; forced to 0 while blanking
//   frame_start  one-clock pulse after pixel (0,0) has been captured
// -----------------------------------------------------------------------------
module vga_scan #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [23:0] vga_data,
    output logic [9:0]  h_addr,
    output logic [9:0]  v_addr,
    output logic        hsync,
    output logic        vsync,
    output logic        valid,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b,
    output logic        frame_start
);

    localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // The boundaries are sized to the counter width once here, so that the
    // comparisons below operate on operands of equal width.
    localparam logic [9:0] H_LAST       = 10'(HT - 1);
    localparam logic [9:0] V_LAST       = 10'(VT - 1);
    localparam logic [9:0] H_ACT        = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT        = 10'(V_ACTIVE);
    localparam logic [9:0] H_SYNC_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_SYNC_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] V_SYNC_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_SYNC_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic       active;
    logic       hsync_next;
    logic       vsync_next;
    logic       first_pixel;

    // Decode of the current counter position. These feed both the frame
    // store address and the output registers.
    always_comb begin
        active      = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        hsync_next  = !((h_cnt >= H_SYNC_START) && (h_cnt < H_SYNC_END));
        vsync_next  = !((v_cnt >= V_SYNC_START) && (v_cnt < V_SYNC_END));
        first_pixel = (h_cnt == 10'd0) && (v_cnt == 10'd0);
    end

    // Outside the active area the address is parked at 0. The frame store
    // then never sees an out-of-range coordinate.
    assign h_addr = active ? h_cnt : 10'd0;
    assign v_addr = active ? v_cnt : 10'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt       <= 10'd0;
            v_cnt       <= 10'd0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            valid       <= 1'b0;
            vga_r       <= 8'd0;
            vga_g       <= 8'd0;
            vga_b       <= 8'd0;
            frame_start <= 1'b0;
        end else begin
            // Default low: the pulse cannot stretch across a stalled (en=0) edge.
            frame_start <= 1'b0;
            if (en) begin
                // A line wrap advances the line counter. A frame wrap clears both.
                if (h_cnt == H_LAST) begin
                    h_cnt <= 10'd0;
                    if (v_cnt == V_LAST) begin
                        v_cnt <= 10'd0;
                    end else begin
                        v_cnt <= v_cnt + 10'd1;
                    end
                end else begin
                    h_cnt <= h_cnt + 10'd1;
                end

                hsync       <= hsync_next;
                vsync       <= vsync_next;
                valid       <= active;
                frame_start <= first_pixel;
                // Blank to black whatever the frame store returns.
                if (active) begin
                    {vga_r, vga_g, vga_b} <= vga_data;
                end else begin
                    {vga_r, vga_g, vga_b} <= 24'h0;
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_scan.sv
// -----------------------------------------------------------------------------
// tb_vga_scan
//
// Uses two instances of vga_scan:
//   dut   - reduced timing so that whole frames run in a few hundred clocks:
//           H: 8 active, 2 FP, 3 sync, 2 BP  -> HT = 15, hsync low h=10..12
//           V: 6 active, 1 FP, 2 sync, 1 BP  -> VT = 10, vsync low v=7..8
//           frame = 150 clocks, 48 active pixels, vsync low 30 clocks
//   dut_d - default 640x480 timing, used for line timing
//           (hsync 656 after the first pixel, 96 wide, period 800)
// Frame store stub: vga_data = {h_addr[7:0], v_addr[7:0], 8'hA5}, or
// 24'hFFFFFF while force_white is set.
// In the comments below, "edge k" means the k-th clocked edge after reset.
// With en held high, edge k captures raster position p = k-1.
// -----------------------------------------------------------------------------
module tb_vga_scan;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic        force_white = 1'b0;
  logic [23:0] vga_data;
  logic [9:0]  h_addr, v_addr;
  logic        hsync, vsync, valid, frame_start;
  logic [7:0]  vga_r, vga_g, vga_b;
  logic [23:0] rgb;

  logic        d_rst = 1'b1;
  logic        d_en  = 1'b0;
  logic [23:0] d_data;
  logic [9:0]  d_h_addr, d_v_addr;
  logic        d_hsync, d_vsync, d_valid, d_frame_start;
  logic [7:0]  d_r, d_g, d_b;

  assign vga_data = force_white ? 24'hFFFFFF : {h_addr[7:0], v_addr[7:0], 8'hA5};
  assign rgb      = {vga_r, vga_g, vga_b};
  assign d_data   = {d_h_addr[7:0], d_v_addr[7:0], 8'h5A};

  vga_scan #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .vga_data(vga_data),
    .h_addr(h_addr), .v_addr(v_addr), .hsync(hsync), .vsync(vsync),
    .valid(valid), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .frame_start(frame_start)
  );

  vga_scan dut_d (
    .clk(clk), .rst(d_rst), .en(d_en), .vga_data(d_data),
    .h_addr(d_h_addr), .v_addr(d_v_addr), .hsync(d_hsync), .vsync(d_vsync),
    .valid(d_valid), .vga_r(d_r), .vga_g(d_g), .vga_b(d_b),
    .frame_start(d_frame_start)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en  = 1'b0;
    step();
    rst = 1'b0;
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic        rst;
    logic        en;
    logic        hs;
    logic        vs;
    logic        val;
    logic        fs;
    logic [23:0] rgb;
    logic [9:0]  ha;
    logic [9:0]  va;
  } vec_t;

  vec_t vecs[8];

  // Free-running scan on the small DUT. m=1: en always high. m=2: en toggles,
  // so every timing figure doubles and the en=0 edges must hold the outputs.
  task automatic run_scan(input int m, input int n_steps, input int exp_falls, input int exp_fs);
    logic        p_hs, p_vs, p_val, p_fs;
    logic [23:0] p_rgb;
    logic [9:0]  p_ha, p_va;
    int first_v, last_fall, falls, low_run, last_fs, fs_n, val_cnt, vs_cnt;
    p_hs = 1'b1; p_vs = 1'b1; p_val = 1'b0; p_fs = 1'b0; p_rgb = '0;
    p_ha = '0; p_va = '0;
    first_v = -1; last_fall = -1; falls = 0; low_run = 0;
    last_fs = -1; fs_n = 0; val_cnt = 0; vs_cnt = 0;
    for (int t = 1; t <= n_steps; t++) begin
      en = (m == 1) ? 1'b1 : ((t % 2) == 1);
      step();
      if (!en) begin
        check("hold_hsync", hsync, p_hs);
        check("hold_vsync", vsync, p_vs);
        check("hold_valid", valid, p_val);
        check("hold_rgb", rgb, p_rgb);
        check("hold_h_addr", h_addr, p_ha);
        check("hold_v_addr", v_addr, p_va);
        check("hold_fs_low", frame_start, 0);
      end
      if (valid && first_v < 0) first_v = t;
      if (p_hs && !hsync) begin
        falls++;
        if (falls == 1) check("hsync_first_fall", t - first_v, 10 * m);
        else            check("hsync_period", t - last_fall, 15 * m);
        last_fall = t;
      end
      if (!hsync) low_run++;
      if (!p_hs && hsync) begin
        check("hsync_width", low_run, 3 * m);
        low_run = 0;
      end
      if (frame_start) begin
        check("fs_width", p_fs, 0);
        if (fs_n > 0) begin
          check("fs_period", t - last_fs, 150 * m);
          check("frame_valid_count", val_cnt, 48 * m);
          check("frame_vsync_low", vs_cnt, 30 * m);
        end
        fs_n++;
        last_fs = t;
        val_cnt = 0;
        vs_cnt  = 0;
      end
      if (valid)  val_cnt++;
      if (!vsync) vs_cnt++;
      p_hs = hsync; p_vs = vsync; p_val = valid; p_fs = frame_start;
      p_rgb = rgb; p_ha = h_addr; p_va = v_addr;
    end
    check("first_valid_edge", first_v, 1);
    check("hsync_fall_count", falls, exp_falls);
    check("fs_count", fs_n, exp_fs);
    en = 1'b0;
  endtask

  initial begin
    // Reset is independent of en. The stalled and advancing edges follow it.
    vecs[0] = '{rst:1, en:1, hs:1, vs:1, val:0, fs:0, rgb:24'h000000, ha:0, va:0};
    vecs[1] = '{rst:0, en:1, hs:1, vs:1, val:1, fs:1, rgb:24'h0000A5, ha:1, va:0};
    vecs[2] = '{rst:0, en:0, hs:1, vs:1, val:1, fs:0, rgb:24'h0000A5, ha:1, va:0};
    vecs[3] = '{rst:0, en:1, hs:1, vs:1, val:1, fs:0, rgb:24'h0100A5, ha:2, va:0};
    vecs[4] = '{rst:0, en:1, hs:1, vs:1, val:1, fs:0, rgb:24'h0200A5, ha:3, va:0};
    vecs[5] = '{rst:0, en:0, hs:1, vs:1, val:1, fs:0, rgb:24'h0200A5, ha:3, va:0};
    vecs[6] = '{rst:1, en:0, hs:1, vs:1, val:0, fs:0, rgb:24'h000000, ha:0, va:0};
    vecs[7] = '{rst:0, en:1, hs:1, vs:1, val:1, fs:1, rgb:24'h0000A5, ha:1, va:0};

    for (int i = 0; i < 8; i++) begin
      rst = vecs[i].rst;
      en  = vecs[i].en;
      step();
      check($sformatf("vec%0d_hsync", i), hsync, vecs[i].hs);
      check($sformatf("vec%0d_vsync", i), vsync, vecs[i].vs);
      check($sformatf("vec%0d_valid", i), valid, vecs[i].val);
      check($sformatf("vec%0d_fs", i), frame_start, vecs[i].fs);
      check($sformatf("vec%0d_rgb", i), rgb, vecs[i].rgb);
      check($sformatf("vec%0d_h_addr", i), h_addr, vecs[i].ha);
      check($sformatf("vec%0d_v_addr", i), v_addr, vecs[i].va);
    end
    rst = 1'b0;
    en  = 1'b0;

    // Spot pixels. Edge 9 captures p=8 (h=8, blanked), which leaves the
    // counter at p=9 (blanked). Edge 34 captures p=33 (h=3, v=2), which
    // leaves the counter at p=34 (h=4, v=2).
    do_reset();
    en = 1'b1;
    for (int k = 1; k <= 34; k++) begin
      step();
      if (k == 9) begin
        check("blank_h8_valid", valid, 0);
        check("blank_h8_rgb", rgb, 24'h0);
        check("blank_h9_h_addr", h_addr, 0);
        check("blank_h9_v_addr", v_addr, 0);
      end
    end
    check("pix_3_2_valid", valid, 1);
    check("pix_3_2_rgb", rgb, 24'h0302A5);
    check("pix_4_2_h_addr", h_addr, 4);
    check("pix_4_2_v_addr", v_addr, 2);
    en = 1'b0;

    // Continuous scan: falls at edges 11+15j up to 320, frame starts at 1, 151, 301.
    do_reset();
    run_scan(1, 320, 21, 3);

    // Toggling enable: falls at 21+30j up to 620, frame starts at 1, 301, 601.
    do_reset();
    run_scan(2, 620, 20, 3);

    // Blanking with a saturated frame store.
    force_white = 1'b1;
    do_reset();
    en = 1'b1;
    for (int k = 1; k <= 150; k++) begin
      step();
      if (valid) check("white_active_rgb", rgb, 24'hFFFFFF);
      else       check("white_blank_rgb", rgb, 24'h0);
    end
    en = 1'b0;
    force_white = 1'b0;

    // Reset mid-frame inside the active area: the counter is at p=50 (h=5, v=3).
    do_reset();
    en = 1'b1;
    repeat (50) step();
    check("mid_h_addr", h_addr, 5);
    check("mid_v_addr", v_addr, 3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_hsync", hsync, 1);
    check("mid_rst_vsync", vsync, 1);
    check("mid_rst_valid", valid, 0);
    check("mid_rst_rgb", rgb, 24'h0);
    check("mid_rst_fs", frame_start, 0);
    check("mid_rst_h_addr", h_addr, 0);
    check("mid_rst_v_addr", v_addr, 0);
    step();
    check("restart_valid", valid, 1);
    check("restart_fs", frame_start, 1);
    check("restart_rgb", rgb, 24'h0000A5);
    check("restart_h_addr", h_addr, 1);

    // Reset while both syncs are low: the last capture was p=115 (h=10, v=7).
    do_reset();
    en = 1'b1;
    repeat (116) step();
    check("sync_region_hsync", hsync, 0);
    check("sync_region_vsync", vsync, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    en  = 1'b0;
    check("sync_rst_hsync", hsync, 1);
    check("sync_rst_vsync", vsync, 1);
    check("sync_rst_valid", valid, 0);
    step();
    check("stall_after_rst_fs", frame_start, 0);
    check("stall_after_rst_valid", valid, 0);

    // Default 640x480 line timing: falls at edges 657, 1457 and 2257.
    begin
      logic p_hs;
      int first_v, last_fall, falls, low_run;
      p_hs = 1'b1; first_v = -1; last_fall = -1; falls = 0; low_run = 0;
      d_rst = 1'b1;
      step();
      d_rst = 1'b0;
      check("d_rst_hsync", d_hsync, 1);
      check("d_rst_valid", d_valid, 0);
      d_en = 1'b1;
      for (int t = 1; t <= 2500; t++) begin
        step();
        if (t == 1) begin
          check("d_first_fs", d_frame_start, 1);
          check("d_first_rgb", {d_r, d_g, d_b}, 24'h00005A);
        end
        if (d_valid && first_v < 0) first_v = t;
        if (p_hs && !d_hsync) begin
          falls++;
          if (falls == 1) check("d_hsync_first_fall", t - first_v, 656);
          else            check("d_hsync_period", t - last_fall, 800);
          last_fall = t;
        end
        if (!d_hsync) low_run++;
        if (!p_hs && d_hsync) begin
          check("d_hsync_width", low_run, 96);
          low_run = 0;
        end
        p_hs = d_hsync;
      end
      check("d_hsync_fall_count", falls, 3);
      d_en = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
